// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: write-back entry record, NOP constants and the
// bubble-mask helper used by the MEM->WB buffer.
package pipe_pkg;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int CSR_AW  = 12;

    localparam logic [RADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [DATA_W-1:0]  ZERO_WORD    = '0;

    typedef struct packed {
        logic [RADDR_W-1:0] wd;
        logic               wreg;
        logic [DATA_W-1:0]  wdata;
        logic               csr_we;
        logic [CSR_AW-1:0]  csr_addr;
        logic [DATA_W-1:0]  csr_data;
    } mem_wb_entry_t;

    localparam int ENTRY_W = $bits(mem_wb_entry_t);

    // An empty stage must look like a NOP to the register and CSR files.
    function automatic mem_wb_entry_t mask_entry(input mem_wb_entry_t e, input logic valid);
        mem_wb_entry_t r;
        r = valid ? e : '0;
        return r;
    endfunction

endpackage

// File: rtl/mem_wb_if.sv
// MEM->WB stage bus. Handshake: a transfer happens on a rising edge where
// valid and ready are both high; ready never depends on the same cycle's valid.
interface mem_wb_if
    import pipe_pkg::*;
#(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [RADDR_W-1:0] in_wd;
    logic               in_wreg;
    logic [DATA_W-1:0]  in_wdata;
    logic               in_csr_we;
    logic [CSR_AW-1:0]  in_csr_addr;
    logic [DATA_W-1:0]  in_csr_data;
    logic               out_valid;
    logic               out_ready;
    logic [RADDR_W-1:0] wb_wd;
    logic               wb_wreg;
    logic [DATA_W-1:0]  wb_wdata;
    logic               wb_csr_reg_we;
    logic [CSR_AW-1:0]  wb_csr_reg_addr;
    logic [DATA_W-1:0]  wb_csr_reg_data;
    logic [CW-1:0]      count;

    modport master (
        output flush, in_valid, in_wd, in_wreg, in_wdata, in_csr_we, in_csr_addr,
               in_csr_data, out_ready,
        input  in_ready, out_valid, wb_wd, wb_wreg, wb_wdata, wb_csr_reg_we,
               wb_csr_reg_addr, wb_csr_reg_data, count
    );

    modport slave (
        input  flush, in_valid, in_wd, in_wreg, in_wdata, in_csr_we, in_csr_addr,
               in_csr_data, out_ready,
        output in_ready, out_valid, wb_wd, wb_wreg, wb_wdata, wb_csr_reg_we,
               wb_csr_reg_addr, wb_csr_reg_data, count
    );

endinterface

// File: rtl/pipe_fifo.sv
// Generic DEPTH-entry FIFO for pipeline stages: any depth, explicit pointer
// wrap, flush clears occupancy and has priority over push/pop.
module pipe_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 wdata_i,
    output logic [W-1:0]                 rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mem_wb_pipe_buf.sv
// MEM->WB elastic stage: buffers up to DEPTH write-back entries, drops x0
// writes at entry, and presents a zeroed NOP bubble while empty.
module mem_wb_pipe_buf
    import pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    mem_wb_if.slave  bus
);

    mem_wb_entry_t entry_in, head, head_q;
    logic          full, empty, push, pop;

    always_comb begin
        entry_in          = '0;
        entry_in.wd       = bus.in_wd;
        entry_in.wreg     = bus.in_wreg & (bus.in_wd != NOP_REG_ADDR);
        entry_in.wdata    = bus.in_wdata;
        entry_in.csr_we   = bus.in_csr_we;
        entry_in.csr_addr = bus.in_csr_addr;
        entry_in.csr_data = bus.in_csr_data;
    end

    // in_ready comes only from registered occupancy, so a pop never opens a push slot.
    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    pipe_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (entry_in),
        .rdata_o (head_q),
        .full_o  (full),
        .empty_o (empty),
        .count_o (bus.count)
    );

    assign head = mask_entry(head_q, bus.out_valid);

    assign bus.wb_wd           = head.wd;
    assign bus.wb_wreg         = head.wreg;
    assign bus.wb_wdata        = head.wdata;
    assign bus.wb_csr_reg_we   = head.csr_we;
    assign bus.wb_csr_reg_addr = head.csr_addr;
    assign bus.wb_csr_reg_data = head.csr_data;

endmodule

// File: tb/tb_mem_wb_pipe_buf.sv
// Directed bench for mem_wb_pipe_buf: DEPTH=2 instance for streaming, back-pressure,
// flush, x0/CSR and reset; DEPTH=3 instance for pointer wrap.
module tb_mem_wb_pipe_buf;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_wb_if #(.DEPTH(2)) bus2();
    mem_wb_if #(.DEPTH(3)) bus3();

    mem_wb_pipe_buf #(.DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    mem_wb_pipe_buf #(.DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv2(input logic v, input logic [4:0] wd, input logic [31:0] wdata);
        bus2.in_valid    = v;
        bus2.in_wd       = wd;
        bus2.in_wreg     = 1'b1;
        bus2.in_wdata    = wdata;
        bus2.in_csr_we   = 1'b0;
        bus2.in_csr_addr = '0;
        bus2.in_csr_data = '0;
    endtask

    task automatic drv3(input logic v, input logic [4:0] wd, input logic [31:0] wdata);
        bus3.in_valid    = v;
        bus3.in_wd       = wd;
        bus3.in_wreg     = 1'b1;
        bus3.in_wdata    = wdata;
        bus3.in_csr_we   = 1'b0;
        bus3.in_csr_addr = '0;
        bus3.in_csr_data = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus2.flush = 1'b0; bus2.out_ready = 1'b0; drv2(1'b0, 5'd0, 32'h0);
        bus3.flush = 1'b0; bus3.out_ready = 1'b0; drv3(1'b0, 5'd0, 32'h0);

        // reset state
        #2;
        chk("rst_out_valid", bus2.out_valid, 0);
        chk("rst_count", bus2.count, 0);
        chk("rst_in_ready", bus2.in_ready, 1);
        chk("rst_wb_wdata", bus2.wb_wdata, 0);
        chk("rst_d3_in_ready", bus3.in_ready, 1);
        #10 rst = 1'b1;

        // stream: each entry visible for one cycle, count stays at 1
        bus2.out_ready = 1'b1;
        drv2(1'b1, 5'd3, 32'hA5A5_0001);
        tick();
        chk("str_a_count", bus2.count, 1);
        chk("str_a_wd", bus2.wb_wd, 3);
        chk("str_a_wdata", bus2.wb_wdata, 32'hA5A5_0001);
        chk("str_a_wreg", bus2.wb_wreg, 1);
        drv2(1'b1, 5'd4, 32'h0000_0002);
        tick();
        chk("str_b_count", bus2.count, 1);
        chk("str_b_wd", bus2.wb_wd, 4);
        chk("str_b_wdata", bus2.wb_wdata, 32'h2);
        drv2(1'b0, 5'd0, 32'h0);
        tick();
        chk("str_end_valid", bus2.out_valid, 0);
        chk("str_end_wd", bus2.wb_wd, 0);

        // back-pressure: third entry held by MEM until a slot frees
        bus2.out_ready = 1'b0;
        drv2(1'b1, 5'd5, 32'h11);
        tick();
        chk("bp_1_count", bus2.count, 1);
        chk("bp_1_ready", bus2.in_ready, 1);
        drv2(1'b1, 5'd6, 32'h22);
        tick();
        chk("bp_2_count", bus2.count, 2);
        chk("bp_2_ready", bus2.in_ready, 0);
        drv2(1'b1, 5'd7, 32'h33);
        tick();
        chk("bp_3_count", bus2.count, 2);
        chk("bp_3_head", bus2.wb_wd, 5);
        bus2.out_ready = 1'b1;
        tick();
        chk("bp_pop1_count", bus2.count, 1);
        chk("bp_pop1_head", bus2.wb_wd, 6);
        chk("bp_pop1_ready", bus2.in_ready, 1);
        tick();
        chk("bp_pop2_count", bus2.count, 1);
        chk("bp_pop2_head", bus2.wb_wd, 7);
        chk("bp_pop2_wdata", bus2.wb_wdata, 32'h33);
        drv2(1'b0, 5'd0, 32'h0);
        tick();
        chk("bp_drain_count", bus2.count, 0);

        // simultaneous push and pop at count=1
        bus2.out_ready = 1'b0;
        drv2(1'b1, 5'd8, 32'h44);
        tick();
        chk("sim_pre_count", bus2.count, 1);
        bus2.out_ready = 1'b1;
        drv2(1'b1, 5'd9, 32'h55);
        tick();
        chk("sim_count", bus2.count, 1);
        chk("sim_head", bus2.wb_wd, 9);
        chk("sim_wdata", bus2.wb_wdata, 32'h55);
        drv2(1'b0, 5'd0, 32'h0);
        tick();
        chk("sim_drain", bus2.count, 0);

        // flush with a full buffer and a pending push
        bus2.out_ready = 1'b0;
        drv2(1'b1, 5'd10, 32'h66);
        tick();
        drv2(1'b1, 5'd11, 32'h77);
        tick();
        chk("fl_full_count", bus2.count, 2);
        bus2.flush = 1'b1;
        bus2.out_ready = 1'b1;
        drv2(1'b1, 5'd12, 32'h88);
        tick();
        chk("fl_count", bus2.count, 0);
        chk("fl_valid", bus2.out_valid, 0);
        chk("fl_ready", bus2.in_ready, 1);
        chk("fl_wd", bus2.wb_wd, 0);
        bus2.flush = 1'b0;
        drv2(1'b0, 5'd0, 32'h0);
        tick();
        chk("fl_not_stored", bus2.count, 0);

        // x0 write dropped, CSR channel passes
        bus2.out_ready = 1'b0;
        drv2(1'b1, 5'd0, 32'hDEAD);
        bus2.in_csr_we   = 1'b1;
        bus2.in_csr_addr = 12'h305;
        bus2.in_csr_data = 32'h8000_0000;
        tick();
        chk("x0_wreg", bus2.wb_wreg, 0);
        chk("x0_csr_we", bus2.wb_csr_reg_we, 1);
        chk("x0_csr_addr", bus2.wb_csr_reg_addr, 12'h305);
        chk("x0_csr_data", bus2.wb_csr_reg_data, 32'h8000_0000);
        drv2(1'b1, 5'd13, 32'h99);
        tick();
        chk("mid_full_count", bus2.count, 2);
        drv2(1'b0, 5'd0, 32'h0);

        // asynchronous reset between edges with two entries held
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", bus2.out_valid, 0);
        chk("arst_count", bus2.count, 0);
        chk("arst_wreg", bus2.wb_wreg, 0);
        chk("arst_csr_we", bus2.wb_csr_reg_we, 0);
        chk("arst_ready", bus2.in_ready, 1);
        #2 rst = 1'b1;
        bus2.out_ready = 1'b0;

        // DEPTH=3: fill, then stream through so both pointers wrap
        bus3.out_ready = 1'b0;
        drv3(1'b1, 5'd11, 32'hB1);
        tick();
        drv3(1'b1, 5'd12, 32'hB2);
        tick();
        drv3(1'b1, 5'd13, 32'hB3);
        tick();
        chk("w3_full_count", bus3.count, 3);
        chk("w3_full_ready", bus3.in_ready, 0);
        chk("w3_head0", bus3.wb_wd, 11);
        bus3.out_ready = 1'b1;
        drv3(1'b1, 5'd14, 32'hB4);
        tick();
        chk("w3_pop1_count", bus3.count, 2);
        chk("w3_pop1_head", bus3.wb_wd, 12);
        tick();
        chk("w3_pop2_count", bus3.count, 2);
        chk("w3_pop2_head", bus3.wb_wd, 13);
        drv3(1'b1, 5'd15, 32'hB5);
        tick();
        chk("w3_pop3_count", bus3.count, 2);
        chk("w3_pop3_head", bus3.wb_wd, 14);
        chk("w3_pop3_wdata", bus3.wb_wdata, 32'hB4);
        drv3(1'b0, 5'd0, 32'h0);
        tick();
        chk("w3_pop4_head", bus3.wb_wd, 15);
        chk("w3_pop4_wdata", bus3.wb_wdata, 32'hB5);
        tick();
        chk("w3_empty_count", bus3.count, 0);
        chk("w3_empty_valid", bus3.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
